// File: rtl/chnl_dump_ctrl_pkg.sv
// Shared types and constants for the channel dump controller.
package dump_pkg;

    localparam int DEF_ENTRIES = 512;

    localparam logic [1:0] CH1     = 2'b00;
    localparam logic [1:0] CH2     = 2'b01;
    localparam logic [1:0] CH3     = 2'b10;
    localparam logic [1:0] CH_RSVD = 2'b11;

    typedef enum logic [2:0] {IDLE, RD, LATCH, SEND, WAIT} state_t;

endpackage

// File: rtl/chnl_dump_ctrl_if.sv
// UART response handshake between the dump controller and the comm block.
interface chnl_dump_ctrl_if #(parameter int DW = 8);
    logic [DW-1:0] resp_data;
    logic          send_resp;
    logic          resp_sent;

    modport master (output resp_data, output send_resp, input resp_sent);
    modport slave  (input resp_data, input send_resp, output resp_sent);
endinterface

// File: rtl/chnl_dump_ctrl_addr_ctr.sv
// Wrapping RAM read address plus byte counter; last flags the final byte.
module dump_addr_ctr #(
    parameter int ENTRIES = 512,
    parameter int AW      = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    input  logic          clr,
    output logic [AW-1:0] addr,
    output logic          last
);
    logic [AW-1:0] cnt;

    // ENTRIES is a power of two, so plain AW-bit rollover is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
            cnt  <= '0;
        end else begin
            if (load)     addr <= load_val;
            else if (inc) addr <= addr + 1'b1;
            if (clr)      cnt  <= '0;
            else if (inc) cnt  <= cnt + 1'b1;
        end
    end

    assign last = (cnt == AW'(ENTRIES - 1));
endmodule

// File: rtl/chnl_dump_ctrl.sv
// Streams one channel RAM to the host, oldest sample first, one UART byte at a time.
module chnl_dump_ctrl
    import dump_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int AW      = 9,
    parameter int DW      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_dump,
    input  logic [1:0]        ch_sel,
    input  logic [AW-1:0]     trace_end,
    input  logic              abort,
    input  logic [DW-1:0]     ch1_rdata,
    input  logic [DW-1:0]     ch2_rdata,
    input  logic [DW-1:0]     ch3_rdata,
    output logic              en,
    output logic [AW-1:0]     addr,
    output logic              dump_busy,
    output logic              dump_done,
    output logic              dump_err,
    chnl_dump_ctrl_if.master  uart
);
    state_t        state, nxt;
    logic [1:0]    ch_lat;
    logic [DW-1:0] resp_q, rd_mux;
    logic          ld, inc, last, send;

    dump_addr_ctr #(.ENTRIES(ENTRIES), .AW(AW)) u_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld),
        .load_val (trace_end + 1'b1),
        .inc      (inc),
        .clr      (ld),
        .addr     (addr),
        .last     (last)
    );

    always_comb begin
        nxt      = state;
        ld       = 1'b0;
        inc      = 1'b0;
        en       = 1'b0;
        send     = 1'b0;
        dump_err = 1'b0;
        case (state)
            IDLE: if (start_dump) begin
                if (ch_sel == CH_RSVD) dump_err = 1'b1;
                else begin
                    ld  = 1'b1;
                    nxt = RD;
                end
            end
            RD: begin
                en  = 1'b1;
                nxt = LATCH;
            end
            LATCH: nxt = SEND;
            SEND: begin
                send = 1'b1;
                nxt  = WAIT;
            end
            WAIT: if (uart.resp_sent) begin
                inc = !last;
                nxt = last ? IDLE : RD;
            end
            default: nxt = IDLE;
        endcase
        // Abort outranks everything, including a resp_sent in the same cycle.
        if (abort && state != IDLE) begin
            nxt  = IDLE;
            inc  = 1'b0;
            send = 1'b0;
        end
    end

    always_comb begin
        case (ch_lat)
            CH1:     rd_mux = ch1_rdata;
            CH2:     rd_mux = ch2_rdata;
            CH3:     rd_mux = ch3_rdata;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch_lat    <= '0;
            resp_q    <= '0;
            dump_done <= 1'b0;
        end else begin
            state     <= nxt;
            if (ld) ch_lat <= ch_sel;
            if (state == LATCH && !abort) resp_q <= rd_mux;
            dump_done <= (state == WAIT) && uart.resp_sent && last && !abort;
        end
    end

    assign dump_busy      = (state != IDLE);
    assign uart.send_resp = send;
    assign uart.resp_data = resp_q;
endmodule

// File: tb/tb_chnl_dump_ctrl.sv
// Directed bench for chnl_dump_ctrl: table of full dumps plus abort/override/reset sequences.
module tb_chnl_dump_ctrl;
    logic       clk, rst_n, start_dump, abort;
    logic [1:0] ch_sel;
    logic [8:0] trace_end, addr, ram_a;
    logic [7:0] ch1_rdata, ch2_rdata, ch3_rdata;
    logic       en, dump_busy, dump_done, dump_err;
    bit         foreign, noise;
    int         hold_idx;

    chnl_dump_ctrl_if #(.DW(8)) uif ();

    chnl_dump_ctrl #(.ENTRIES(512), .AW(9), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_dump(start_dump), .ch_sel(ch_sel),
        .trace_end(trace_end), .abort(abort), .ch1_rdata(ch1_rdata),
        .ch2_rdata(ch2_rdata), .ch3_rdata(ch3_rdata), .en(en), .addr(addr),
        .dump_busy(dump_busy), .dump_done(dump_done), .dump_err(dump_err),
        .uart(uif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: one-cycle read latency; ch1/ch2 can be forced to AA/55.
    always @(posedge clk) if (en) ram_a <= addr;
    assign ch1_rdata = foreign ? 8'hAA : ram_a[7:0];
    assign ch2_rdata = foreign ? 8'h55 : ~ram_a[7:0];
    assign ch3_rdata = ram_a[7:0] ^ 8'h3C;

    // UART model: resp_sent 2 clks after send_resp (20 on byte hold_idx), optional stray pulses.
    initial begin
        int pend, nb;
        pend = 0;
        nb = 0;
        uif.resp_sent = 1'b0;
        forever begin
            @(negedge clk);
            uif.resp_sent = 1'b0;
            if (!dump_busy) begin
                pend = 0;
                nb = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) uif.resp_sent = 1'b1;
            end else if (uif.send_resp) begin
                pend = (nb == hold_idx) ? 20 : 2;
                nb++;
                if (noise) uif.resp_sent = 1'b1;
            end else if (noise && en) uif.resp_sent = 1'b1;
        end
    end

    typedef struct {
        logic [1:0] cs;
        logic [8:0] te;
        bit         foreign;
        bit         noise;
        int         hold;
        bit         exp_err;
        logic [8:0] exp_first;
        logic [8:0] exp_last;
        logic [7:0] exp_b0;
        logic [7:0] exp_bl;
    } vec_t;

    int         n_vec, n_bad;
    logic [8:0] q_addr[$];
    logic [7:0] q_data[$];
    int         n_send, n_done, n_err, n_busy, hold_viol, abort_busy, rst_vec, timed_out;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [1:0] cs, input logic [8:0] a, input bit frn);
        case (cs)
            2'b00:   exp_byte = frn ? 8'hAA : a[7:0];
            2'b01:   exp_byte = frn ? 8'h55 : ~a[7:0];
            default: exp_byte = a[7:0] ^ 8'h3C;
        endcase
    endfunction

    task automatic run(input logic [1:0] cs, input logic [8:0] te,
                       input int abort_at, input int ovr_at, input int rst_at);
        int idle_run, arm;
        logic [8:0] pa;
        logic [7:0] pd;
        q_addr.delete();
        q_data.delete();
        n_send = 0; n_done = 0; n_err = 0; n_busy = 0; hold_viol = 0;
        abort_busy = -1; rst_vec = -1; timed_out = 0;
        idle_run = 0; arm = 0;
        @(negedge clk);
        ch_sel = cs; trace_end = te; start_dump = 1'b1;
        pa = addr; pd = uif.resp_data;
        for (int c = 0; c < 6000 && idle_run < 4; c++) begin
            @(negedge clk);
            if (abort) abort_busy = int'(dump_busy);
            if (en) q_addr.push_back(addr);
            if (uif.send_resp) begin
                q_data.push_back(uif.resp_data);
                n_send++;
            end
            if (dump_done) n_done++;
            if (dump_err) n_err++;
            if (dump_busy) begin n_busy++; idle_run = 0; end
            else idle_run++;
            if (dump_busy && !en && addr != pa) hold_viol++;
            if (!uif.send_resp && uif.resp_data != pd) hold_viol++;
            pa = addr; pd = uif.resp_data;
            abort = 1'b0; start_dump = 1'b0;
            if (arm > 0) begin
                arm--;
                if (arm == 0) abort = 1'b1;
            end
            if (uif.send_resp && n_send == abort_at) arm = 2;
            if (uif.send_resp && n_send == ovr_at) begin
                start_dump = 1'b1;
                ch_sel = (cs == 2'b00) ? 2'b01 : 2'b00;
                trace_end = te ^ 9'h0F0;
            end
            if (uif.send_resp && n_send == rst_at) begin
                rst_n = 1'b0;
                #1;
                rst_vec = int'({en, addr, uif.resp_data, uif.send_resp, dump_busy, dump_done, dump_err});
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
        end
        if (idle_run < 4 && rst_vec < 0) timed_out = 1;
    endtask

    task automatic check_seq(input logic [1:0] cs, input logic [8:0] te, input bit frn);
        int bad_a, bad_d;
        bad_a = 0; bad_d = 0;
        foreach (q_addr[i]) if (q_addr[i] != 9'(int'(te) + 1 + i)) bad_a++;
        foreach (q_data[i]) if (q_data[i] != exp_byte(cs, 9'(int'(te) + 1 + i), frn)) bad_d++;
        check("addr_seq_bad", bad_a, 0);
        check("data_seq_bad", bad_d, 0);
    endtask

    task automatic check_full(input logic [1:0] cs, input logic [8:0] te, input bit frn,
                              input logic [8:0] ef, input logic [8:0] el,
                              input logic [7:0] eb0, input logic [7:0] ebl);
        check("timeout", timed_out, 0);
        check("err_pulses", n_err, 0);
        check("en_cycles", q_addr.size(), 512);
        check("send_pulses", n_send, 512);
        check("done_pulses", n_done, 1);
        check("hold_viol", hold_viol, 0);
        check("first_addr", q_addr.size() > 0 ? int'(q_addr[0]) : -1, int'(ef));
        check("last_addr", q_addr.size() > 0 ? int'(q_addr[q_addr.size()-1]) : -1, int'(el));
        check("first_byte", q_data.size() > 0 ? int'(q_data[0]) : -1, int'(eb0));
        check("last_byte", q_data.size() > 0 ? int'(q_data[q_data.size()-1]) : -1, int'(ebl));
        check("busy_after", int'(dump_busy), 0);
        check("resp_data_kept", int'(uif.resp_data), int'(ebl));
        check_seq(cs, te, frn);
    endtask

    initial begin
        vec_t tbl[5];
        tbl[0] = '{2'b00, 9'h1FF, 1'b0, 1'b0, -1, 1'b0, 9'h000, 9'h1FF, 8'h00, 8'hFF};
        tbl[1] = '{2'b10, 9'h005, 1'b1, 1'b0, -1, 1'b0, 9'h006, 9'h005, 8'h3A, 8'h39};
        tbl[2] = '{2'b01, 9'h0AA, 1'b0, 1'b0, -1, 1'b0, 9'h0AB, 9'h0AA, 8'h54, 8'h55};
        tbl[3] = '{2'b11, 9'h010, 1'b0, 1'b0, -1, 1'b1, 9'h000, 9'h000, 8'h00, 8'h00};
        tbl[4] = '{2'b00, 9'h100, 1'b0, 1'b1,  3, 1'b0, 9'h101, 9'h100, 8'h01, 8'h00};

        n_vec = 0; n_bad = 0;
        rst_n = 1'b0; start_dump = 1'b0; abort = 1'b0; ch_sel = 2'b00; trace_end = 9'h000;
        foreign = 1'b0; noise = 1'b0; hold_idx = -1;
        #12;
        check("reset_outputs", int'({en, addr, uif.resp_data, uif.send_resp, dump_busy, dump_done, dump_err}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            foreign = tbl[k].foreign; noise = tbl[k].noise; hold_idx = tbl[k].hold;
            run(tbl[k].cs, tbl[k].te, -1, -1, -1);
            if (tbl[k].exp_err) begin
                check("rsvd_err_pulses", n_err, 1);
                check("rsvd_en_cycles", q_addr.size(), 0);
                check("rsvd_busy_cycles", n_busy, 0);
                check("rsvd_send_pulses", n_send, 0);
            end else
                check_full(tbl[k].cs, tbl[k].te, tbl[k].foreign, tbl[k].exp_first,
                           tbl[k].exp_last, tbl[k].exp_b0, tbl[k].exp_bl);
        end

        // Abort in WAIT of byte 100, coincident with its resp_sent.
        foreign = 1'b0; noise = 1'b0; hold_idx = -1;
        run(2'b00, 9'h0FF, 100, -1, -1);
        check("abort_timeout", timed_out, 0);
        check("abort_send_pulses", n_send, 100);
        check("abort_done_pulses", n_done, 0);
        check("abort_busy_next", abort_busy, 0);
        check("abort_en_cycles", q_addr.size(), 100);
        check_seq(2'b00, 9'h0FF, 1'b0);
        run(2'b00, 9'h0FF, -1, -1, -1);
        check_full(2'b00, 9'h0FF, 1'b0, 9'h100, 9'h0FF, 8'h00, 8'hFF);

        // start_dump with new ch_sel/trace_end mid-dump must be ignored.
        run(2'b00, 9'h03F, -1, 200, -1);
        check_full(2'b00, 9'h03F, 1'b0, 9'h040, 9'h03F, 8'h40, 8'h3F);

        // Reset mid-dump clears every output at once.
        run(2'b10, 9'h1F0, -1, -1, 50);
        check("midreset_outputs", rst_vec, 0);
        check("midreset_done", n_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/chnl_dump_ctrl.md
Name: chnl_dump_ctrl

Overview:
- Sequences a channel dump after a capture completes.
- Reads all ENTRIES samples of one channel RAM in chronological order, oldest sample first, starting at the entry just after trace_end.
- Sends each byte to the HOST through the UART response handshake.
- Sits between the command/config block (which decodes the DUMP_CH command and issues start_dump), the shared channel RAMs, and the UART comm block.

Parameters:
ENTRIES  512  samples per channel RAM; must be a power of 2
AW       9    RAM address width, log2(ENTRIES)
DW       8    sample width

Ports:
clk         in   1    system clock
rst_n       in   1    asynchronous active-low reset
start_dump  in   1    1-cycle request to begin a dump; sampled only in IDLE
ch_sel      in   2    channel to dump: 00=ch1, 01=ch2, 10=ch3, 11=reserved
trace_end   in   AW   address of the newest captured sample
abort       in   1    synchronous abort of a dump in progress
ch1_rdata   in   DW   channel 1 RAM read data
ch2_rdata   in   DW   channel 2 RAM read data
ch3_rdata   in   DW   channel 3 RAM read data
en          out  1    RAM read enable
addr        out  AW   RAM read address
resp_data   out  DW   byte to the UART
send_resp   out  1    1-cycle pulse that starts a UART send
resp_sent   in   1    UART send finished
dump_busy   out  1    high whenever state != IDLE
dump_done   out  1    1-cycle pulse after the last byte's resp_sent
dump_err    out  1    1-cycle pulse when start_dump arrives with ch_sel=11

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: all outputs 0; state IDLE; addr register 0; byte counter 0; latched channel 0.
- States: IDLE, RD, LATCH, SEND, WAIT.
- IDLE:
  - start_dump with ch_sel != 11: latch ch_sel; addr <= trace_end+1 (mod ENTRIES, so 1FF wraps to 000); cnt <= 0; go to RD.
  - start_dump with ch_sel = 11: dump_err=1 for that single cycle; stay in IDLE; no RAM access.
- RD: en=1 with addr driven; go to LATCH.
- LATCH: resp_data <= selected chX_rdata (RAM read latency is 1 clk); go to SEND.
- SEND: send_resp=1 for exactly one cycle, with resp_data already stable; go to WAIT.
- WAIT: hold resp_data until resp_sent=1. Then:
  - cnt == ENTRIES-1: dump_done pulse next cycle; go to IDLE.
  - otherwise: addr <= addr+1 (wraps mod ENTRIES); cnt <= cnt+1; go to RD.
- resp_sent is sampled only in WAIT and ignored in all other states.
- Per-byte latency: 3 clks from entering RD to send_resp, plus the UART time.
- Total dump: exactly ENTRIES bytes; the addresses cover every location exactly once.
- Counter: AW bits; the last byte is cnt == ENTRIES-1, with no overflow bit.
- en is 0 outside RD. addr holds its value outside RD.
- resp_data retains the last byte after the dump.
- start_dump while busy: ignored, with no effect on the current dump.
- abort in any non-IDLE state: IDLE on the next clk; no dump_done; send_resp never issued in that cycle. abort has priority over resp_sent.
- Reset mid-dump: immediate return to IDLE and reset values; no pulses.
- ch_sel and trace_end are captured at start; changes during a dump have no effect.

Decomposition:
- Shared package dump_pkg:
  - state_t enum {IDLE, RD, LATCH, SEND, WAIT}
  - localparams CH1=2'b00, CH2=2'b01, CH3=2'b10, CH_RSVD=2'b11
  - default ENTRIES
- One natural sub-module, dump_addr_ctr: the wrapping address register plus byte counter. Inputs are load (value trace_end+1), inc and clr; output is last.
- The FSM and the read-data mux stay in chnl_dump_ctrl.

Test Plan:
- ch_sel=00, trace_end=1FF, RAM[i]=i[7:0], resp_sent 2 clks after each send_resp:
  - first addr=000, last addr=1FF;
  - 512 send_resp pulses, bytes 00..FF, 00..FF;
  - dump_done 1 cycle; dump_busy low afterwards.
- ch_sel=10, trace_end=005:
  - addr sequence 006..1FF, then 000..005;
  - data taken from ch3_rdata only (ch1/ch2 driven AA/55 must never appear).
- ch_sel=11 start -> dump_err=1 for exactly 1 cycle; en never asserted; dump_busy stays 0.
- resp_sent held off 20 clks on byte 3:
  - send_resp is a single pulse;
  - addr, en and resp_data hold;
  - extra resp_sent pulses in RD/SEND are ignored.
- abort asserted in WAIT of byte 100 -> IDLE next clk; no dump_done; 100 send_resp pulses total; a new start_dump then dumps all 512 bytes.
- start_dump pulsed mid-dump with a different ch_sel -> ignored; sequence and channel unchanged; rst_n asserted mid-dump -> all outputs 0 immediately.
